// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the register scoreboard and its entries.
package cpu_pkg;

    localparam int REGISTERCOUNT   = 16;
    localparam int REGADDRBITWIDTH = $clog2(REGISTERCOUNT);
    localparam int TAGBITWIDTH     = 6;

    typedef logic [REGADDRBITWIDTH-1:0] reg_addr_t;
    typedef logic [TAGBITWIDTH-1:0]     tag_t;

endpackage

// File: rtl/scoreboard_entry.sv
// One register's pending bit and issue tag, with writeback tag matching.
module scoreboard_entry
    import cpu_pkg::*;
#(
    parameter int INDEX     = 0,
    parameter int ADDRW     = REGADDRBITWIDTH,
    parameter int TAGW      = TAGBITWIDTH,
    parameter int WBPORTS   = 2,
    parameter bit CONSTZERO = 1'b0
) (
    input  logic                     clk,
    input  logic                     async_rst,
    input  logic                     clk_en,
    input  logic                     flush,
    input  logic                     setEn,
    input  logic [TAGW-1:0]          setTag,
    input  logic [WBPORTS-1:0]       wbValid,
    input  logic [WBPORTS*ADDRW-1:0] wbAddr,
    input  logic [WBPORTS*TAGW-1:0]  wbTag,
    output logic                     pending,
    output logic                     clear,
    output logic                     pendingNext
);

    localparam logic [ADDRW-1:0] MYADDR = ADDRW'(INDEX);

    logic [TAGW-1:0] tagStore;
    logic            wbHit;
    logic            doSet;

    // Several ports matching in one cycle still collapse into a single clear.
    always_comb begin
        wbHit = 1'b0;
        for (int p = 0; p < WBPORTS; p++) begin
            if (wbValid[p] && (wbAddr[p*ADDRW +: ADDRW] == MYADDR) &&
                (wbTag[p*TAGW +: TAGW] == tagStore)) begin
                wbHit = 1'b1;
            end
        end
    end

    assign clear = pending && wbHit;
    assign doSet = setEn && !CONSTZERO;

    // Flush beats everything; a fresh issue beats a same-cycle clear.
    always_comb begin
        pendingNext = pending;
        if (flush) begin
            pendingNext = 1'b0;
        end else if (doSet) begin
            pendingNext = 1'b1;
        end else if (clear) begin
            pendingNext = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            pending  <= 1'b0;
            tagStore <= '0;
        end else if (clk_en) begin
            pending <= pendingNext;
            if (!flush && doSet) begin
                tagStore <= setTag;
            end
        end
    end

endmodule

// File: rtl/register_scoreboard.sv
// Register-hazard scoreboard: per-register pending tracking with tagged writeback clears.
module register_scoreboard #(
    parameter int REGISTERCOUNT   = cpu_pkg::REGISTERCOUNT,
    parameter int REGADDRBITWIDTH = $clog2(REGISTERCOUNT),
    parameter int TAGBITWIDTH     = cpu_pkg::TAGBITWIDTH,
    parameter int WBPORTS         = 2,
    parameter bit ZEROREG_CONST   = 1'b1,
    parameter bit WB_BYPASS       = 1'b1
) (
    input  logic                               clk,
    input  logic                               async_rst,
    input  logic                               clk_en,
    input  logic                               IssueValid,
    input  logic                               IssueRdEn,
    input  logic [REGADDRBITWIDTH-1:0]         IssueRdAddr,
    input  logic [TAGBITWIDTH-1:0]             IssueTag,
    input  logic                               ReadA_En,
    input  logic [REGADDRBITWIDTH-1:0]         ReadA_Addr,
    input  logic                               ReadB_En,
    input  logic [REGADDRBITWIDTH-1:0]         ReadB_Addr,
    input  logic [WBPORTS-1:0]                 WbValid,
    input  logic [WBPORTS*REGADDRBITWIDTH-1:0] WbAddr,
    input  logic [WBPORTS*TAGBITWIDTH-1:0]     WbTag,
    input  logic                               FlushEn,
    output logic                               IssueAccept,
    output logic                               RegisterStall,
    output logic [REGISTERCOUNT-1:0]           PendingVector,
    output logic [REGADDRBITWIDTH:0]           PendingCount,
    output logic                               RegistersSync
);

    logic [REGISTERCOUNT-1:0] clearVec;
    logic [REGISTERCOUNT-1:0] busyVec;
    logic [REGISTERCOUNT-1:0] pendingNextVec;
    logic                     issueWrite;

    function automatic logic [REGADDRBITWIDTH:0] popCount(input logic [REGISTERCOUNT-1:0] v);
        logic [REGADDRBITWIDTH:0] c;
        c = '0;
        for (int i = 0; i < REGISTERCOUNT; i++) begin
            c = c + {{REGADDRBITWIDTH{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign issueWrite = IssueAccept && IssueRdEn;

    for (genvar r = 0; r < REGISTERCOUNT; r++) begin : gEntry
        localparam bit ISCONST = ZEROREG_CONST && (r == 0);

        scoreboard_entry #(
            .INDEX    (r),
            .ADDRW    (REGADDRBITWIDTH),
            .TAGW     (TAGBITWIDTH),
            .WBPORTS  (WBPORTS),
            .CONSTZERO(ISCONST)
        ) uEntry (
            .clk        (clk),
            .async_rst  (async_rst),
            .clk_en     (clk_en),
            .flush      (FlushEn),
            .setEn      (issueWrite && (IssueRdAddr == REGADDRBITWIDTH'(r))),
            .setTag     (IssueTag),
            .wbValid    (WbValid),
            .wbAddr     (WbAddr),
            .wbTag      (WbTag),
            .pending    (PendingVector[r]),
            .clear      (clearVec[r]),
            .pendingNext(pendingNextVec[r])
        );

        // With bypass, a writeback landing this cycle already satisfies the reader.
        assign busyVec[r] = PendingVector[r] && !(WB_BYPASS && clearVec[r]) && !ISCONST;
    end

    always_comb begin
        RegisterStall = 1'b0;
        if (IssueValid) begin
            RegisterStall = (ReadA_En  && busyVec[ReadA_Addr]) ||
                            (ReadB_En  && busyVec[ReadB_Addr]) ||
                            (IssueRdEn && busyVec[IssueRdAddr]);
        end
    end

    assign IssueAccept   = IssueValid && !RegisterStall && !FlushEn;
    assign RegistersSync = ~|PendingVector;

    // Count tracks the next pending vector so it lines up with PendingVector.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            PendingCount <= '0;
        end else if (clk_en) begin
            PendingCount <= popCount(pendingNextVec);
        end
    end

endmodule

// File: tb/tb_register_scoreboard.sv
// Randomized bench for register_scoreboard against an array-based pending/tag model.
module tb_register_scoreboard;

    localparam int NR = 16;
    localparam int AW = 4;
    localparam int TW = 6;
    localparam int NP = 2;

    logic          clk = 1'b0;
    logic          async_rst = 1'b0;
    logic          clk_en;
    logic          IssueValid, IssueRdEn, ReadA_En, ReadB_En, FlushEn;
    logic [AW-1:0] IssueRdAddr, ReadA_Addr, ReadB_Addr;
    logic [TW-1:0] IssueTag;
    logic [NP-1:0] WbValid;
    logic [NP*AW-1:0] WbAddr;
    logic [NP*TW-1:0] WbTag;
    logic          IssueAccept, RegisterStall, RegistersSync;
    logic [NR-1:0] PendingVector;
    logic [AW:0]   PendingCount;

    bit            checkOn = 1'b0;
    int            nChecks = 0;
    int            nFail = 0;

    bit            mPend [NR];
    logic [TW-1:0] mTag  [NR];

    always #5 clk = ~clk;

    register_scoreboard #(
        .REGISTERCOUNT(NR), .REGADDRBITWIDTH(AW), .TAGBITWIDTH(TW),
        .WBPORTS(NP), .ZEROREG_CONST(1'b1), .WB_BYPASS(1'b1)
    ) dut (
        .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
        .IssueValid(IssueValid), .IssueRdEn(IssueRdEn), .IssueRdAddr(IssueRdAddr),
        .IssueTag(IssueTag), .ReadA_En(ReadA_En), .ReadA_Addr(ReadA_Addr),
        .ReadB_En(ReadB_En), .ReadB_Addr(ReadB_Addr), .WbValid(WbValid),
        .WbAddr(WbAddr), .WbTag(WbTag), .FlushEn(FlushEn),
        .IssueAccept(IssueAccept), .RegisterStall(RegisterStall),
        .PendingVector(PendingVector), .PendingCount(PendingCount),
        .RegistersSync(RegistersSync)
    );

    function automatic bit mClear(int r);
        if (!mPend[r]) return 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (WbValid[p] && (int'(WbAddr[p*AW +: AW]) == r) && (WbTag[p*TW +: TW] == mTag[r]))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit mBusy(int r);
        return (r != 0) && mPend[r] && !mClear(r);
    endfunction

    function automatic bit mStall();
        return IssueValid && ((ReadA_En && mBusy(int'(ReadA_Addr))) ||
                              (ReadB_En && mBusy(int'(ReadB_Addr))) ||
                              (IssueRdEn && mBusy(int'(IssueRdAddr))));
    endfunction

    function automatic bit mAccept();
        return IssueValid && !mStall() && !FlushEn;
    endfunction

    function automatic int mVector();
        int v = 0;
        for (int r = 0; r < NR; r++) if (mPend[r]) v |= (1 << r);
        return v;
    endfunction

    function automatic int mCount();
        int c = 0;
        for (int r = 0; r < NR; r++) c += int'(mPend[r]);
        return c;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: evaluated on the same edge the DUT state would move.
    always @(posedge clk or posedge async_rst) begin : modelUpdate
        bit clr [NR];
        bit acc;
        if (async_rst) begin
            for (int r = 0; r < NR; r++) begin
                mPend[r] = 1'b0;
                mTag[r]  = '0;
            end
        end else if (clk_en) begin
            acc = mAccept();
            for (int r = 0; r < NR; r++) clr[r] = mClear(r);
            if (FlushEn) begin
                for (int r = 0; r < NR; r++) mPend[r] = 1'b0;
            end else begin
                for (int r = 0; r < NR; r++) if (clr[r]) mPend[r] = 1'b0;
                if (acc && IssueRdEn && IssueRdAddr != 0) begin
                    mPend[IssueRdAddr] = 1'b1;
                    mTag[IssueRdAddr]  = IssueTag;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checkOn) begin
            checkOutput("stall",  int'(RegisterStall), int'(mStall()));
            checkOutput("accept", int'(IssueAccept),   int'(mAccept()));
            checkOutput("pendVec", int'(PendingVector), mVector());
            checkOutput("pendCount", int'(PendingCount), mCount());
            checkOutput("sync", int'(RegistersSync), int'(mCount() == 0));
        end
    end

    task automatic applyStimulus(input bit v, input bit rdEn, input int rd, input int tg,
                                 input bit aEn, input int a, input bit bEn, input int b,
                                 input logic [1:0] wv, input int wa0, input int wt0,
                                 input int wa1, input int wt1, input bit fl, input bit en);
        IssueValid  = v;
        IssueRdEn   = rdEn;
        IssueRdAddr = AW'(rd);
        IssueTag    = TW'(tg);
        ReadA_En    = aEn;
        ReadA_Addr  = AW'(a);
        ReadB_En    = bEn;
        ReadB_Addr  = AW'(b);
        WbValid     = wv;
        WbAddr      = {AW'(wa1), AW'(wa0)};
        WbTag       = {TW'(wt1), TW'(wt0)};
        FlushEn     = fl;
        clk_en      = en;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic issue(input int rd, input int tg);
        applyStimulus(1, 1, rd, tg, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic writeback0(input int wa, input int wt);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, wa, wt, 0, 0, 0, 1);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic randomStep();
        int r0, r1;
        r0 = int'($urandom_range(NR-1));
        r1 = int'($urandom_range(NR-1));
        applyStimulus($urandom_range(9) < 7, $urandom_range(1), int'($urandom_range(NR-1)),
                      int'($urandom_range(3)), $urandom_range(1), int'($urandom_range(NR-1)),
                      $urandom_range(1), int'($urandom_range(NR-1)), 2'($urandom_range(3)),
                      r0, ($urandom_range(3) == 0) ? int'($urandom_range(3)) : int'(mTag[r0]),
                      r1, ($urandom_range(3) == 0) ? int'($urandom_range(3)) : int'(mTag[r1]),
                      $urandom_range(49) == 0, $urandom_range(9) != 0);
    endtask

    initial begin
        idle();
        #1 async_rst = 1'b1;
        checkOn = 1'b1;
        #2;
        checkOutput("rstVec",   int'(PendingVector), 0);
        checkOutput("rstCount", int'(PendingCount), 0);
        checkOutput("rstSync",  int'(RegistersSync), 1);
        checkOutput("rstStall", int'(RegisterStall), 0);
        repeat (2) @(posedge clk);
        #2 async_rst = 1'b0;

        // RAW hazard resolved by a bypassed writeback on port 1
        nextCycle(); issue(5, 'h03);
        #1 checkOutput("rawIssueAccept", int'(IssueAccept), 1);
        nextCycle(); applyStimulus(1, 0, 0, 0, 1, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        #1 checkOutput("rawStall", int'(RegisterStall), 1);
        checkOutput("rawNoAccept", int'(IssueAccept), 0);
        checkOutput("rawPend5", int'(PendingVector[5]), 1);
        applyStimulus(1, 0, 0, 0, 1, 5, 0, 0, 2'b10, 0, 0, 5, 'h03, 0, 1);
        #1 checkOutput("bypassStall", int'(RegisterStall), 0);
        checkOutput("bypassAccept", int'(IssueAccept), 1);
        nextCycle(); idle();
        #1 checkOutput("rawCleared5", int'(PendingVector[5]), 0);

        // Stale writeback on register 7
        nextCycle(); issue(7, 'h10);
        nextCycle(); writeback0(7, 'h0F);
        nextCycle(); idle();
        #1 checkOutput("stalePend7", int'(PendingVector[7]), 1);
        checkOutput("staleCount", int'(PendingCount), 1);

        // Same-cycle clear and re-issue of register 4
        nextCycle(); issue(4, 'h01);
        nextCycle(); applyStimulus(1, 1, 4, 'h02, 0, 0, 0, 0, 2'b01, 4, 'h01, 0, 0, 0, 1);
        #1 checkOutput("reissueAccept", int'(IssueAccept), 1);
        nextCycle(); writeback0(4, 'h01);
        #1 checkOutput("reissuePend4", int'(PendingVector[4]), 1);
        nextCycle(); writeback0(4, 'h02);
        #1 checkOutput("oldTagIgnored", int'(PendingVector[4]), 1);
        nextCycle(); writeback0(7, 'h10);
        #1 checkOutput("newTagClears", int'(PendingVector[4]), 0);
        nextCycle(); idle();
        #1 checkOutput("allClearCount", int'(PendingCount), 0);

        // Flush gated by clk_en
        nextCycle(); issue(1, 'h21);
        nextCycle(); issue(2, 'h22);
        nextCycle(); issue(3, 'h23);
        nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        #1 checkOutput("preFlushCount", int'(PendingCount), 3);
        nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1);
        #1 checkOutput("gatedFlushCount", int'(PendingCount), 3);
        checkOutput("gatedFlushVec", int'(PendingVector), 'h000E);
        nextCycle(); idle();
        #1 checkOutput("flushCount", int'(PendingCount), 0);
        checkOutput("flushSync", int'(RegistersSync), 1);

        // Constant register 0
        nextCycle(); issue(0, 'h05);
        #1 checkOutput("zeroAccept", int'(IssueAccept), 1);
        nextCycle(); applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        #1 checkOutput("zeroStall", int'(RegisterStall), 0);
        checkOutput("zeroVec", int'(PendingVector), 0);

        // Reset in the middle of operation
        nextCycle(); issue(9, 'h09);
        nextCycle(); idle();
        #1 checkOutput("midPend9", int'(PendingVector[9]), 1);
        async_rst = 1'b1;
        #1 checkOutput("midRstVec", int'(PendingVector), 0);
        checkOutput("midRstCount", int'(PendingCount), 0);
        nextCycle(); async_rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            nextCycle();
            randomStep();
        end

        nextCycle(); idle();
        nextCycle();
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
